// File: rtl/sim_ctrl_pkg.sv
// Shared state encoding and halt-cause codes for the simulation run/dump sequencer.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] HALT_NONE  = 2'b00;
  localparam logic [1:0] HALT_LIMIT = 2'b01;
  localparam logic [1:0] HALT_REQ   = 2'b10;
  localparam logic [1:0] HALT_STALL = 2'b11;

endpackage

// File: rtl/sim_run_controller_if.sv
// RAM dump port: synchronous read request/data plus the registered dump stream.
interface sim_run_controller_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              dump_rd;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_word;

  modport master (
    output dump_rd, dump_addr, dump_valid, dump_idx, dump_word,
    input  dump_data
  );

  modport slave (
    input  dump_rd, dump_addr, dump_valid, dump_idx, dump_word,
    output dump_data
  );
endinterface

// File: rtl/sim_run_controller_pc_stall_detector.sv
// Flags a run that keeps presenting the same PC for STALL_CYCLES consecutive run cycles.
// Only instantiated when PC_STALL_DETECT_EN is defined.
module pc_stall_detector
  import sim_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STALL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  output logic              stall
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W:0] HIT = (CNT_W + 1)'(STALL_CYCLES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] prev_q, prev_d;
  logic              have_q, have_d;
  logic              same;
  logic [CNT_W:0]    cnt_ext;

  always_comb begin
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    have_d  = have_q;
    same    = have_q && (pc == prev_q);
    cnt_ext = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    stall   = en && same && (cnt_ext >= HIT);
    // Leaving RUN forgets the previous PC so the first cycle of the next run never compares.
    if (!en) begin
      cnt_d  = '0;
      have_d = 1'b0;
    end else begin
      prev_d = pc;
      have_d = 1'b1;
      if (!same) cnt_d = '0;
      else if (cnt_ext <= HIT) cnt_d = cnt_ext[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prev_q <= '0;
      have_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
      have_q <= have_d;
    end
  end

endmodule

// File: rtl/sim_run_controller.sv
// Run/dump sequencer: holds the CPU in reset, runs it for a bounded number of cycles, then streams
// a RAM window out one word per cycle. Optional PC stall detection under PC_STALL_DETECT_EN.
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter int                CYC_W        = 32,
  parameter int                RST_HOLD     = 2,
  parameter int                MAX_CYCLES   = 50,
  parameter logic [ADDR_W-1:0] DUMP_BASE    = '0,
  parameter int                DUMP_LEN     = 10,
  parameter int                STALL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic [ADDR_W-1:0]    pc,
  sim_run_controller_if.master dbus,
  output logic                 cpu_rst,
  output logic                 cpu_run,
  output logic [CYC_W-1:0]     cycle_count,
  output logic [1:0]           halt_cause,
  output logic                 done
);

  localparam int RST_W = $clog2(RST_HOLD + 1);
  localparam logic [RST_W-1:0] LAST_RST = RST_W'(RST_HOLD - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((DUMP_LEN > 0) ? DUMP_LEN - 1 : 0);
  // Limit compare is wider than the counter so a saturated small counter never aliases the limit.
  localparam int CMP_W = ((CYC_W > 32) ? CYC_W : 32) + 1;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(MAX_CYCLES);

  state_t             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;
  logic [1:0]         halt_cause_q, halt_cause_d;
  logic               dump_vld_p1_q, dump_vld_p1_d;
  logic [ADDR_W-1:0]  dump_idx_p1_q, dump_idx_p1_d;
  logic               dump_rd;
  logic [ADDR_W-1:0]  dump_addr;
  logic [CMP_W-1:0]   cyc_next_ext;
  logic               stall;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

`ifdef PC_STALL_DETECT_EN
  pc_stall_detector #(
    .ADDR_W      (ADDR_W),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_stall (
    .clk  (clk),
    .rst  (rst),
    .en   (cpu_run),
    .pc   (pc),
    .stall(stall)
  );
`else
  logic unused_pc;
  assign unused_pc = (^pc) ^ (STALL_CYCLES > 0);
  assign stall     = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    idx_d         = idx_q;
    cycle_count_d = cycle_count_q;
    halt_cause_d  = halt_cause_q;
    dump_rd       = 1'b0;
    cyc_next_ext  = CMP_W'(cycle_count_q) + CMP_W'(1);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_RESET;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          halt_cause_d  = HALT_NONE;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == LAST_RST) state_d = ST_RUN;
        else rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      ST_RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        idx_d         = '0;
        if (halt_req) begin
          halt_cause_d = HALT_REQ;
          state_d      = ST_DUMP;
        end else if (stall) begin
          halt_cause_d = HALT_STALL;
          state_d      = ST_DUMP;
        end else if (cyc_next_ext == LIMIT) begin
          halt_cause_d = HALT_LIMIT;
          state_d      = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (DUMP_LEN == 0) begin
          state_d = ST_DONE;
        end else begin
          dump_rd = 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_DRAIN;
          else idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    dump_addr     = dump_rd ? (DUMP_BASE + idx_q) : '0;
    dump_vld_p1_d = dump_rd;
    dump_idx_p1_d = dump_rd ? idx_q : dump_idx_p1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      idx_q         <= '0;
      cycle_count_q <= '0;
      halt_cause_q  <= HALT_NONE;
      dump_vld_p1_q <= 1'b0;
      dump_idx_p1_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      idx_q         <= idx_d;
      cycle_count_q <= cycle_count_d;
      halt_cause_q  <= halt_cause_d;
      // p1: beat aligned with the RAM's registered read data
      dump_vld_p1_q <= dump_vld_p1_d;
      dump_idx_p1_q <= dump_idx_p1_d;
    end
  end

  assign cpu_rst         = (state_q == ST_IDLE) || (state_q == ST_RESET);
  assign cpu_run         = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign cycle_count     = cycle_count_q;
  assign halt_cause      = halt_cause_q;
  assign dbus.dump_rd    = dump_rd;
  assign dbus.dump_addr  = dump_addr;
  assign dbus.dump_valid = dump_vld_p1_q;
  assign dbus.dump_idx   = dump_idx_p1_q;
  assign dbus.dump_word  = dump_vld_p1_q ? dbus.dump_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: default instance plus wrap-dump and empty-dump/saturation variants.
module tb_sim_run_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  start_v = '0;
  logic [2:0]  halt_v  = '0;
  logic [15:0] pc_v [3];
  logic [31:0] cc0, cc1;
  logic [2:0]  cc2;
  logic [1:0]  hc [3];
  logic [2:0]  o_rst, o_run, o_done, o_rd, o_vld;
  logic [31:0] o_cc [3];
  logic [15:0] o_addr [3];
  logic [15:0] o_idx [3];
  logic [15:0] o_word [3];
  int total = 0;
  int bad   = 0;

  sim_run_controller_if if0 ();
  sim_run_controller_if if1 ();
  sim_run_controller_if if2 ();

  sim_run_controller u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .halt_req(halt_v[0]), .pc(pc_v[0]), .dbus(if0),
    .cpu_rst(o_rst[0]), .cpu_run(o_run[0]), .cycle_count(cc0), .halt_cause(hc[0]), .done(o_done[0])
  );

  sim_run_controller #(.MAX_CYCLES(3), .DUMP_BASE(16'hFFFE), .DUMP_LEN(4)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .halt_req(halt_v[1]), .pc(pc_v[1]), .dbus(if1),
    .cpu_rst(o_rst[1]), .cpu_run(o_run[1]), .cycle_count(cc1), .halt_cause(hc[1]), .done(o_done[1])
  );

  sim_run_controller #(.CYC_W(3), .MAX_CYCLES(20), .DUMP_LEN(0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .halt_req(halt_v[2]), .pc(pc_v[2]), .dbus(if2),
    .cpu_rst(o_rst[2]), .cpu_run(o_run[2]), .cycle_count(cc2), .halt_cause(hc[2]), .done(o_done[2])
  );

  // Synchronous-read RAM models: word at address a is a ^ 16'hA5C3
  always @(posedge clk) begin
    if (if0.dump_rd) if0.dump_data <= if0.dump_addr ^ 16'hA5C3;
    if (if1.dump_rd) if1.dump_data <= if1.dump_addr ^ 16'hA5C3;
    if (if2.dump_rd) if2.dump_data <= if2.dump_addr ^ 16'hA5C3;
  end

  assign o_cc[0] = cc0;
  assign o_cc[1] = cc1;
  assign o_cc[2] = {29'd0, cc2};
  assign o_rd  = {if2.dump_rd, if1.dump_rd, if0.dump_rd};
  assign o_vld = {if2.dump_valid, if1.dump_valid, if0.dump_valid};
  assign o_addr[0] = if0.dump_addr;
  assign o_addr[1] = if1.dump_addr;
  assign o_addr[2] = if2.dump_addr;
  assign o_idx[0]  = if0.dump_idx;
  assign o_idx[1]  = if1.dump_idx;
  assign o_idx[2]  = if2.dump_idx;
  assign o_word[0] = if0.dump_word;
  assign o_word[1] = if1.dump_word;
  assign o_word[2] = if2.dump_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start instance k, drive pc/halt/start during RUN, record the whole run and dump, check the outcome.
  task automatic run_seq(input string nm, input int k, input int halt_at, input bit stall_pc,
                         input bit extra_start, input int base, input int len,
                         input int exp_run, input int exp_cc, input int exp_hc);
    int rst_n = 0, run_n = 0, rd_n = 0, vld_n = 0, addr_err = 0, data_err = 0;
    bit fin = 1'b0;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      halt_v[k]  = 1'b0;
      start_v[k] = 1'b0;
      if (o_rst[k]) rst_n++;
      if (o_run[k]) begin
        run_n++;
        halt_v[k]  = (run_n == halt_at);
        pc_v[k]    = (stall_pc && run_n >= 5) ? 16'h0012 : 16'(run_n);
        start_v[k] = extra_start && (run_n == 3);
      end
      if (o_rd[k]) begin
        if (o_addr[k] !== 16'(base + rd_n)) addr_err++;
        rd_n++;
      end
      if (o_vld[k]) begin
        if (o_idx[k] !== 16'(vld_n) || o_word[k] !== (16'(base + vld_n) ^ 16'hA5C3)) data_err++;
        vld_n++;
      end
      if (o_done[k]) fin = 1'b1;
      else tick();
    end
    halt_v[k]  = 1'b0;
    start_v[k] = 1'b0;
    chk({nm, "_done"}, 32'(fin), 32'd1);
    chk({nm, "_rst_cycles"}, rst_n, 2);
    chk({nm, "_run_cycles"}, run_n, exp_run);
    chk({nm, "_rd_count"}, rd_n, len);
    chk({nm, "_rd_addr_errs"}, addr_err, 0);
    chk({nm, "_vld_count"}, vld_n, len);
    chk({nm, "_vld_data_errs"}, data_err, 0);
    chk({nm, "_cycle_count"}, o_cc[k], exp_cc);
    chk({nm, "_halt_cause"}, 32'(hc[k]), exp_hc);
    chk({nm, "_done_cpu_rst"}, 32'(o_rst[k]), 32'd0);
    chk({nm, "_done_cpu_run"}, 32'(o_run[k]), 32'd0);
  endtask

  initial begin
    int run_n;
    for (int i = 0; i < 3; i++) pc_v[i] = 16'h0000;
    tick();
    tick();
    chk("rst_cpu_rst", 32'(o_rst[0]), 32'd1);
    chk("rst_cpu_run", 32'(o_run[0]), 32'd0);
    chk("rst_done", 32'(o_done[0]), 32'd0);
    chk("rst_dump_rd", 32'(o_rd[0]), 32'd0);
    chk("rst_dump_valid", 32'(o_vld[0]), 32'd0);
    chk("rst_cycle_count", o_cc[0], 32'd0);
    chk("rst_halt_cause", 32'(hc[0]), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_cpu_rst", 32'(o_rst[0]), 32'd1);
    chk("idle_done", 32'(o_done[0]), 32'd0);

    run_seq("plain", 0, 0, 1'b0, 1'b0, 0, 10, 50, 50, 1);
    run_seq("halt7", 0, 7, 1'b0, 1'b1, 0, 10, 7, 7, 2);
    run_seq("halt50", 0, 50, 1'b0, 1'b0, 0, 10, 50, 50, 2);
`ifdef PC_STALL_DETECT_EN
    run_seq("stall", 0, 0, 1'b1, 1'b0, 0, 10, 8, 8, 3);
`else
    run_seq("stall", 0, 0, 1'b1, 1'b0, 0, 10, 50, 50, 1);
`endif
    run_seq("wrap", 1, 0, 1'b0, 1'b0, 32'hFFFE, 4, 3, 3, 1);
    run_seq("empty_sat", 2, 10, 1'b0, 1'b0, 0, 0, 10, 7, 2);

    // Asynchronous reset in the middle of run cycle 20, then a full replay
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    run_n = 0;
    for (int c = 0; c < 100 && run_n < 20; c++) begin
      if (o_run[0]) begin
        run_n++;
        pc_v[0] = 16'(run_n);
      end
      if (run_n < 20) tick();
    end
    chk("midrst_reached", run_n, 20);
    chk("midrst_pre_count", o_cc[0], 32'd19);
    rst = 1'b1;
    #1;
    chk("midrst_cpu_rst", 32'(o_rst[0]), 32'd1);
    chk("midrst_cpu_run", 32'(o_run[0]), 32'd0);
    chk("midrst_done", 32'(o_done[0]), 32'd0);
    chk("midrst_cycle_count", o_cc[0], 32'd0);
    chk("midrst_halt_cause", 32'(hc[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_seq("replay", 0, 0, 1'b0, 1'b0, 0, 10, 50, 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
